icache_fetch_nway: RTL

- Parametrised N-way set-associative instruction cache for the IF stage; successor to the fixed 2-way, single-lane, miss-flag-only fetch cache.
- Adds dual-lane superscalar fetch (pc and pc+4 in one cycle), a sequential miss/refill FSM with a memory burst handshake, per-set round-robin replacement, whole-cache flush and a miss counter.
- Sits between the PC register and the decode stage; the memory side connects to the L2/memory arbiter.

---
 rtl/icache_fetch_nway.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/icache_fetch_nway.sv
// N-way set-associative instruction cache for the fetch stage: dual-lane lookup
// (pc, pc+4), burst refill FSM, per-set round-robin replacement, flush, miss counter.
module icache_fetch_nway #(
    parameter int N = 2,
    parameter int B = 8,
    parameter int S = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        flush,
    input  logic [63:0] PCF,
    output logic [31:0] instrF0,
    output logic [31:0] instrF1,
    output logic        validF0,
    output logic        validF1,
    output logic        stallF,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    output logic [31:0] miss_count
);
    localparam int SB = $clog2(S);
    localparam int BB = $clog2(B);
    localparam int YB = 3;
    localparam int TB = 64 - SB - BB - YB;
    localparam int WB = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_REFILL = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [63:0]   addr_q;
    logic [WB-1:0] victim_q;
    logic          victim_ptr_q;
    logic [BB-1:0] beat_q;
    logic          flush_pend_q;
    logic [31:0]   miss_q;

    logic [N-1:0]  valid_q [S];
    logic [WB-1:0] ptr_q   [S];
    logic [TB-1:0] tag_q   [N][S];
    logic [63:0]   data_q  [N][S][B];

    logic [SB-1:0] set_idx, rset;
    logic [TB-1:0] tag_in;
    logic [BB-1:0] word0, word0_nxt;
    logic          hit, have_inv, lookup, miss_go, last_instr, beat_last;
    logic [WB-1:0] hit_way, inv_way;
    logic [63:0]   word_a, word_b;
    logic          unused_pc_lsb;

    assign set_idx       = PCF[SB+BB+YB-1:BB+YB];
    assign tag_in        = PCF[63:SB+BB+YB];
    assign word0         = PCF[BB+YB-1:YB];
    assign word0_nxt     = word0 + BB'(1);
    assign rset          = addr_q[SB+BB+YB-1:BB+YB];
    assign unused_pc_lsb = ^PCF[1:0];
    assign last_instr    = &PCF[BB+YB-1:2];
    assign beat_last     = (state_q == ST_REFILL) && mem_rvalid && (beat_q == BB'(B-1));

    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        have_inv = 1'b0;
        inv_way  = '0;
        for (int w = 0; w < N; w++) begin
            if (valid_q[set_idx][w] && tag_q[w][set_idx] == tag_in) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
        end
        // Descending scan so the lowest-numbered invalid way wins.
        for (int w = N - 1; w >= 0; w--) begin
            if (!valid_q[set_idx][w]) begin
                have_inv = 1'b1;
                inv_way  = WB'(w);
            end
        end
    end

    // Reset gates the lookup so stall and outputs drop the instant it asserts.
    assign lookup  = (state_q == ST_IDLE) && enable && !flush && !reset;
    assign miss_go = lookup && !hit;

    assign word_a = data_q[hit_way][set_idx][word0];
    assign word_b = data_q[hit_way][set_idx][word0_nxt];

    always_comb begin
        instrF0 = '0;
        instrF1 = '0;
        validF0 = 1'b0;
        validF1 = 1'b0;
        if (lookup && hit) begin
            validF0 = 1'b1;
            instrF0 = PCF[2] ? word_a[63:32] : word_a[31:0];
            if (!last_instr) begin
                validF1 = 1'b1;
                instrF1 = PCF[2] ? word_b[31:0] : word_a[63:32];
            end
        end
    end

    assign stallF     = (state_q != ST_IDLE) || miss_go;
    assign mem_req    = (state_q == ST_REQ);
    assign mem_addr   = addr_q;
    assign miss_count = miss_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (miss_go && !flush) state_d = ST_REQ;
            ST_REQ:    if (mem_gnt) state_d = ST_REFILL;
            ST_REFILL: if (beat_last) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            victim_q     <= '0;
            victim_ptr_q <= 1'b0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            miss_q       <= '0;
            for (int i = 0; i < S; i++) begin
                valid_q[i] <= '0;
                ptr_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (flush) begin
                        for (int i = 0; i < S; i++) begin
                            valid_q[i] <= '0;
                            ptr_q[i]   <= '0;
                        end
                    end else if (miss_go) begin
                        addr_q       <= {PCF[63:BB+YB], {(BB+YB){1'b0}}};
                        victim_q     <= have_inv ? inv_way : ptr_q[set_idx];
                        victim_ptr_q <= !have_inv;
                        flush_pend_q <= 1'b0;
                        miss_q       <= miss_q + 32'd1;
                    end
                end
                ST_REQ: begin
                    if (flush) flush_pend_q <= 1'b1;
                    if (mem_gnt) beat_q <= '0;
                end
                ST_REFILL: begin
                    if (flush) flush_pend_q <= 1'b1;
                    if (mem_rvalid) beat_q <= beat_q + BB'(1);
                    if (beat_last) begin
                        // A flush seen at any point in the transaction discards the new line too.
                        if (flush_pend_q || flush) begin
                            for (int i = 0; i < S; i++) begin
                                valid_q[i] <= '0;
                                ptr_q[i]   <= '0;
                            end
                        end else begin
                            valid_q[rset][victim_q] <= 1'b1;
                            if (victim_ptr_q) ptr_q[rset] <= (N == 1) ? '0 : victim_q + WB'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_REFILL && mem_rvalid) begin
            data_q[victim_q][rset][beat_q] <= mem_rdata;
            if (beat_q == BB'(B-1)) tag_q[victim_q][rset] <= addr_q[63:SB+BB+YB];
        end
    end
endmodule
